// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and multi-cycle results
// queue in a small FIFO. A per-register scoreboard stalls issue on hazards against those results.
module rf_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              p_wen,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic              m_valid,
  output logic              m_ready,
  input  logic [ADDR_W-1:0] m_waddr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rs,
  input  logic [ADDR_W-1:0] issue_rt,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_rd_en,
  input  logic              issue_long,
  output logic              issue_stall,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [31:0]       pending
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] fifo_addr [DEPTH];
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt, outstanding;
  logic [31:0]       pending_q, pending_nxt;

  logic              full, empty, p_sel, push, pop, hazard, sb_set;
  logic [ADDR_W-1:0] head_addr;

  assign full      = (fifo_cnt == FULL_CNT);
  assign empty     = (fifo_cnt == '0);
  assign m_ready   = !full;
  assign head_addr = fifo_addr[rd_ptr];

  // A pipeline write to r0 is dropped and leaves the port free for a buffered result.
  assign p_sel = p_wen && (p_waddr != '0);
  assign pop   = !p_sel && !empty;
  assign push  = m_valid && !full && (m_waddr != '0);

  always_comb begin
    rf_wen   = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (p_sel) begin
      rf_wen   = 1'b1;
      rf_waddr = p_waddr;
      rf_wdata = p_wdata;
    end else if (!empty) begin
      rf_wen   = 1'b1;
      rf_waddr = head_addr;
      rf_wdata = fifo_data[rd_ptr];
    end
  end

  assign hazard      = pending_q[issue_rs] | pending_q[issue_rt] |
                       (issue_rd_en & pending_q[issue_rd]);
  assign issue_stall = issue_valid & (hazard | (issue_long & (outstanding == FULL_CNT)));
  assign sb_set      = issue_valid & !issue_stall & issue_long & issue_rd_en & (issue_rd != '0);

  // The WAW stall keeps set and clear from ever targeting the same register.
  always_comb begin
    pending_nxt = pending_q;
    if (pop)    pending_nxt[head_addr] = 1'b0;
    if (sb_set) pending_nxt[issue_rd]  = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  assign pending = pending_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
      pending_q   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt    <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
      outstanding <= outstanding + CNT_W'(sb_set) - CNT_W'(pop);
      pending_q   <= pending_nxt;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the control state above.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= m_waddr;
      fifo_data[wr_ptr] <= m_wdata;
    end
  end

  // Every buffered result must belong to an outstanding long op.
  a_fifo_le_outstanding: assert property (@(posedge clk) disable iff (!resetn)
    fifo_cnt <= outstanding);
  a_result_was_issued: assert property (@(posedge clk) disable iff (!resetn)
    push |-> pending_q[m_waddr]);

endmodule
